// File: rtl/mem_store_pkg.sv
// Shared definitions for the store serializer: size encodings, FSM states
// and the size-code to byte-count decode.
package mem_store_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
    logic [3:0] bytes;
    case (size)
      SZ_B:    bytes = 4'd1;
      SZ_H:    bytes = 4'd2;
      SZ_W:    bytes = 4'd4;
      SZ_D:    bytes = 4'd8;
      default: bytes = 4'd1;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/mem_store_fifo.sv
// Two-entry request FIFO placed ahead of the serializer FSM when store
// queueing (MEM_STORE_QUEUE_EN) is built in. Read data is the head entry.
module mem_store_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;

  logic do_push;
  logic do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign rdata   = mem_q[rd_ptr_q];

  // Storage needs no reset: an entry is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer and occupancy tracking; push and pop may share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_store_serializer.sv
// Breaks 1/2/4/8-byte CPU stores into little-endian single-byte RAM writes.
// Optional build macro: MEM_STORE_QUEUE_EN adds a 2-entry request FIFO so
// consecutive stores stream with no idle cycle between them.
//
// state    | meaning
// ST_IDLE  | no store in progress, RAM bus released
// ST_WRITE | emitting byte idx of the latched store, RAM bus owned
module mem_store_serializer
  import mem_store_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              ram_sel,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_d,
  output logic              store_done
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        idx_q;
  logic [3:0]        n_q;

  logic              load;
  logic              last_byte;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [1:0]        ld_size;

  assign last_byte = (state_q == ST_WRITE) && ({1'b0, idx_q} == (n_q - 4'd1));

`ifdef MEM_STORE_QUEUE_EN
  localparam int ENT_W = ADDR_W + DATA_W + 2;

  logic [ENT_W-1:0] fifo_rdata;
  logic             fifo_empty;
  logic             fifo_full;

  // Ready is gated by rst_n so it reads low for the whole reset window.
  assign req_ready = rst_n & ~fifo_full;
  assign load      = ~fifo_empty & ((state_q == ST_IDLE) | last_byte);
  assign {ld_addr, ld_data, ld_size} = fifo_rdata;

  mem_store_fifo #(.W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid & req_ready),
    .wdata ({req_addr, req_data, req_size}),
    .pop   (load),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
`else
  assign req_ready = rst_n & (state_q == ST_IDLE);
  assign load      = req_valid & req_ready;
  assign ld_addr   = req_addr;
  assign ld_data   = req_data;
  assign ld_size   = req_size;
`endif

  // State register plus the latched store and byte cursor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      data_q  <= '0;
      idx_q   <= 3'd0;
      n_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      if (load) begin
        base_q <= ld_addr;
        data_q <= ld_data;
        n_q    <= size_to_bytes(ld_size);
        idx_q  <= 3'd0;
      end else if (state_q == ST_WRITE) begin
        idx_q  <= idx_q + 3'd1;
      end
    end
  end

  // Next state and RAM port drive; outputs depend only on registered state.
  always_comb begin
    state_d    = state_q;
    ram_sel    = 1'b0;
    ram_load   = 1'b0;
    ram_addr   = '0;
    ram_d      = '0;
    store_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ram_sel  = 1'b1;
        ram_load = 1'b1;
        ram_addr = base_q + {{(ADDR_W-3){1'b0}}, idx_q};
        ram_d    = data_q[{idx_q, 3'b000} +: 8];
        if (last_byte) begin
          store_done = 1'b1;
          state_d    = load ? ST_WRITE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_store_serializer.sv
module tb_mem_store_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        ram_sel;
  logic        ram_load;
  logic [15:0] ram_addr;
  logic [7:0]  ram_d;
  logic        store_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:65535];
  int wr_cnt = 0;
  int done_cnt = 0;

  mem_store_serializer #(.ADDR_W(16), .DATA_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .ram_sel    (ram_sel),
    .ram_load   (ram_load),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .store_done (store_done)
  );

  always #5 clk = ~clk;

  // Byte-wide RAM model, written mid-cycle when the write enable is up.
  always @(negedge clk) begin
    if (ram_load === 1'b1) begin
      ram[ram_addr] = ram_d;
      wr_cnt++;
    end
    if (store_done === 1'b1) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request and return in the first write cycle.
  task automatic issue(input logic [15:0] a, input logic [63:0] d, input logic [1:0] s);
    int w = 0;
    req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
    while (req_ready !== 1'b1 && w < 20) begin tick; w++; end
    checks++;
    if (w >= 20) begin
      errors++; $display("FAIL issue_ready: req_ready=%b required 1 within 20 cycles", req_ready);
    end
    tick;
    req_valid = 1'b0;
`ifdef MEM_STORE_QUEUE_EN
    tick;
`endif
  endtask

  task automatic test_reset;
    int w0;
    rst_n = 1'b0; req_valid = 1'b1; req_addr = 16'h1234;
    req_data = 64'hA5A5_A5A5_A5A5_A5A5; req_size = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if ({ram_load, ram_sel, store_done, req_ready} !== 4'b0000) begin
        errors++; $display("FAIL reset_ctrl: load/sel/done/ready=%b required 0000", {ram_load, ram_sel, store_done, req_ready});
      end
      checks++;
      if (ram_addr !== 16'h0000 || ram_d !== 8'h00) begin
        errors++; $display("FAIL reset_bus: addr=%h d=%h required 0000 00", ram_addr, ram_d);
      end
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
    w0 = wr_cnt;
    repeat (3) tick;
    checks++;
    if (ram_load !== 1'b0 || wr_cnt != w0) begin
      errors++; $display("FAIL reset_idle: ram_load=%b writes=%0d required 0 and 0", ram_load, wr_cnt - w0);
    end
  endtask

  task automatic test_store8;
    logic [63:0] rb;
    issue(16'h0009, 64'h1122334455667788, 2'b11);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram_load !== 1'b1 || ram_sel !== 1'b1 || ram_addr !== 16'(16'h0009 + i) ||
          ram_d !== 8'(8'h88 - 8'h11 * i) || store_done !== (i == 7)) begin
        errors++;
        $display("FAIL store8_byte%0d: load=%b sel=%b addr=%h d=%h done=%b required 1 1 %h %h %b",
                 i, ram_load, ram_sel, ram_addr, ram_d, store_done,
                 16'(16'h0009 + i), 8'(8'h88 - 8'h11 * i), (i == 7));
      end
      tick;
    end
    checks++;
    if (req_ready !== 1'b1 || ram_load !== 1'b0 || store_done !== 1'b0) begin
      errors++; $display("FAIL store8_after: ready=%b load=%b done=%b required 1 0 0", req_ready, ram_load, store_done);
    end
    rb = '0;
    for (int i = 0; i < 8; i++) rb[8*i +: 8] = ram[16'h0009 + i];
    checks++;
    if (rb !== 64'h1122334455667788) begin
      errors++; $display("FAIL store8_readback: got %h required 1122334455667788", rb);
    end
  endtask

  task automatic test_store1;
    issue(16'h0049, 64'h00000000000000AB, 2'b00);
    checks++;
    if (ram_load !== 1'b1 || ram_addr !== 16'h0049 || ram_d !== 8'hAB || store_done !== 1'b1) begin
      errors++; $display("FAIL store1_write: load=%b addr=%h d=%h done=%b required 1 0049 ab 1",
                         ram_load, ram_addr, ram_d, store_done);
    end
    tick;
    checks++;
    if (req_ready !== 1'b1 || ram_load !== 1'b0) begin
      errors++; $display("FAIL store1_after: ready=%b load=%b required 1 0", req_ready, ram_load);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] ea [4];
    logic [7:0]  ed [4];
    ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000; ea[3] = 16'h0001;
    ed[0] = 8'hEF;    ed[1] = 8'hBE;    ed[2] = 8'hAD;    ed[3] = 8'hDE;
    issue(16'hFFFE, 64'h00000000DEADBEEF, 2'b10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram_load !== 1'b1 || ram_addr !== ea[i] || ram_d !== ed[i] || store_done !== (i == 3)) begin
        errors++; $display("FAIL wrap_byte%0d: load=%b addr=%h d=%h done=%b required 1 %h %h %b",
                           i, ram_load, ram_addr, ram_d, store_done, ea[i], ed[i], (i == 3));
      end
      tick;
    end
    checks++;
    if (ram_load !== 1'b0) begin
      errors++; $display("FAIL wrap_after: ram_load=%b required 0", ram_load);
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    for (int i = 0; i < 8; i++) ram[16'h0100 + i] = 8'h5A;
    d0 = done_cnt;
    issue(16'h0100, 64'h0807060504030201, 2'b11);
    tick; tick;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_load, ram_sel, store_done, req_ready} !== 4'b0000 || ram_addr !== 16'h0000 || ram_d !== 8'h00) begin
      errors++; $display("FAIL abort_outputs: load/sel/done/ready=%b addr=%h d=%h required 0000 0000 00",
                         {ram_load, ram_sel, store_done, req_ready}, ram_addr, ram_d);
    end
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (3) tick;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[16'h0100 + i] !== ((i < 3) ? 8'(i + 1) : 8'h5A)) begin
        errors++; $display("FAIL abort_mem%0d: got %h required %h", i, ram[16'h0100 + i],
                           ((i < 3) ? 8'(i + 1) : 8'h5A));
      end
    end
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL abort_done: store_done pulses=%0d required 0", done_cnt - d0);
    end
  endtask

`ifndef MEM_STORE_QUEUE_EN
  // Held-valid requests: one idle cycle between stores, inputs sampled only at accept.
  task automatic test_back_to_back;
    issue(16'h0200, 64'h000000000000C3B2, 2'b01);
    req_valid = 1'b1; req_addr = 16'h0300; req_data = 64'h000000000000F1E0; req_size = 2'b01;
    checks++;
    if (ram_addr !== 16'h0200 || ram_d !== 8'hB2 || req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first0: addr=%h d=%h ready=%b required 0200 b2 0", ram_addr, ram_d, req_ready);
    end
    tick;
    checks++;
    if (ram_addr !== 16'h0201 || ram_d !== 8'hC3 || store_done !== 1'b1) begin
      errors++; $display("FAIL b2b_first1: addr=%h d=%h done=%b required 0201 c3 1", ram_addr, ram_d, store_done);
    end
    tick;
    checks++;
    if (ram_load !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: load=%b ready=%b required 0 1", ram_load, req_ready);
    end
    tick;
    req_valid = 1'b0;
    checks++;
    if (ram_load !== 1'b1 || ram_addr !== 16'h0300 || ram_d !== 8'hE0) begin
      errors++; $display("FAIL b2b_second: load=%b addr=%h d=%h required 1 0300 e0", ram_load, ram_addr, ram_d);
    end
    repeat (2) tick;
  endtask
`else
  // Three consecutive 4-byte pushes must stream as 12 gapless write cycles.
  task automatic test_queue;
    logic        l_load [24];
    logic        l_done [24];
    logic [15:0] l_addr [24];
    logic [7:0]  l_d    [24];
    logic [63:0] sd [3];
    int f;
    sd[0] = 64'h44332211; sd[1] = 64'h88776655; sd[2] = 64'hCCBBAA99;
    for (int c = 0; c < 24; c++) begin
      if (c < 3) begin
        req_valid = 1'b1; req_addr = 16'(16'h0400 + 4 * c); req_data = sd[c]; req_size = 2'b10;
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL queue_accept%0d: req_ready=%b required 1", c, req_ready);
        end
      end else begin
        req_valid = 1'b0;
      end
      l_load[c] = ram_load; l_done[c] = store_done; l_addr[c] = ram_addr; l_d[c] = ram_d;
      tick;
    end
    f = -1;
    for (int c = 0; c < 8; c++) if (f < 0 && l_load[c] === 1'b1) f = c;
    checks++;
    if (f < 0) begin
      errors++; $display("FAIL queue_start: no ram_load within 8 cycles, required one");
    end else begin
      for (int j = 0; j < 12; j++) begin
        checks++;
        if (l_load[f+j] !== 1'b1 || l_addr[f+j] !== 16'(16'h0400 + j) ||
            l_d[f+j] !== 8'(8'h11 * (j + 1)) || l_done[f+j] !== ((j % 4) == 3)) begin
          errors++; $display("FAIL queue_byte%0d: load=%b addr=%h d=%h done=%b required 1 %h %h %b",
                             j, l_load[f+j], l_addr[f+j], l_d[f+j], l_done[f+j],
                             16'(16'h0400 + j), 8'(8'h11 * (j + 1)), ((j % 4) == 3));
        end
      end
      checks++;
      if (l_load[f+12] !== 1'b0) begin
        errors++; $display("FAIL queue_end: ram_load=%b after 12 writes required 0", l_load[f+12]);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    test_reset;
    test_store8;
    test_store1;
    test_wrap;
`ifndef MEM_STORE_QUEUE_EN
    test_back_to_back;
`else
    test_queue;
`endif
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_store_serializer.md
Name: mem_store_serializer

Overview:
- Sits directly upstream of the byte-wide main RAM write port (load/addr/d, 16-bit address, 8-bit data).
- Accepts 1/2/4/8-byte store requests from the CPU execute stage and emits them as consecutive single-byte writes, little-endian, at addr, addr+1, ….
- While it writes, it owns the RAM address bus; the top level muxes RAM addr using ram_sel.
- Byte order is the one the RAM's 64-bit little-endian read assembles, so a store followed by a load returns the stored value.

Parameters:
- ADDR_W, 16, RAM byte-address width.
- DATA_W, 64, widest store payload in bits (must be 64).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  serializer can accept a request
- req_addr  in  ADDR_W  first byte address
- req_data  in  DATA_W  store data; byte i = req_data[8i+7:8i]
- req_size  in  2  00=1, 01=2, 10=4, 11=8 bytes
- ram_sel  out  1  serializer drives RAM addr this cycle
- ram_load  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM byte address
- ram_d  out  8  RAM write byte
- store_done  out  1  one-cycle pulse on the cycle of the final byte write

Behaviour:
- Reset values: req_ready=0 while rst_n low, then 1 in IDLE; ram_sel=0, ram_load=0, ram_addr=0, ram_d=0, store_done=0.
- Internal state: base address, data register, byte index idx (3 bits), byte count n.
- FSM has two states, IDLE and WRITE.
- IDLE:
  - req_ready=1 and all RAM outputs are inactive (ram_load=0, ram_sel=0).
  - On req_valid&&req_ready at edge k: latch addr/data, set n from req_size, idx=0, go to WRITE.
- WRITE:
  - Each cycle: ram_sel=1, ram_load=1, ram_addr=base+idx (modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000), ram_d=data byte idx.
  - All outputs are combinational from registered state, so the RAM captures the byte at the end of the same cycle.
  - idx increments each cycle.
  - When idx==n-1: store_done=1 that cycle, and the next state is IDLE.
- Latency: a request accepted at edge k writes its bytes in cycles k+1 … k+n. req_ready is high again in cycle k+n+1.
- Throughput (no queue): n+1 cycles per store.
- req_ready=0 throughout WRITE; req_valid is ignored there. Request inputs are sampled only at acceptance.
- Size 1: exactly one write cycle, with store_done in that cycle.
- rst_n asserted mid-WRITE: immediate abort with outputs at reset values; unwritten bytes are never written; no store_done.
- No other abort path exists.
- Same-cycle accept and completion never occur without the queue feature.

Optional Feature:
- Macro: MEM_STORE_QUEUE_EN.
- Defined:
  - A 2-entry FIFO of {addr,data,size} sits in front of the FSM.
  - req_ready = FIFO not full, independent of FSM state.
  - The FSM pops the FIFO in IDLE, or in the final-byte cycle of WRITE; in the latter case WRITE restarts next cycle, so back-to-back stores run with zero gap cycles.
  - A push and a pop in the same cycle are both honoured; push while full is impossible since ready=0.
  - Reset empties the FIFO.
- Undefined: no FIFO; behaviour exactly as above.

Decomposition:
- Shared package mem_store_pkg holds:
  - size encoding constants SZ_B/SZ_H/SZ_W/SZ_D = 0..3;
  - FSM state enum {ST_IDLE, ST_WRITE};
  - function size_to_bytes(2-bit) returning 1/2/4/8.
- One sub-module, mem_store_fifo: 2-deep synchronous FIFO with async active-low reset, instantiated only under MEM_STORE_QUEUE_EN.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> ram_load=0, ram_sel=0, store_done=0, req_ready=0; after release req_ready=1 and no write happens until valid&&ready.
- 8-byte store: addr=0x0009, data=0x1122334455667788, size=11 -> cycles k+1..k+8 write 0x88,0x77,…,0x11 to 0x0009..0x0010; store_done in cycle k+8 only; a readback of addr 0x0009 returns 0x1122334455667788.
- 1-byte store: addr=0x0049, data=0xAB, size=00 -> a single cycle with ram_addr=0x0049, ram_d=0xAB, store_done=1; req_ready high in the following cycle.
- Wrap: addr=0xFFFE, size=10, data=0xDEADBEEF -> writes 0xEF@0xFFFE, 0xBE@0xFFFF, 0xAD@0x0000, 0xDE@0x0001.
- Reset mid-op: 8-byte store at 0x0100, rst_n low after the 3rd write cycle -> only 0x0100..0x0102 written, outputs drop to reset values asynchronously, no store_done.
- With MEM_STORE_QUEUE_EN: three 4-byte stores presented on consecutive cycles -> all accepted, 12 contiguous ram_load cycles with no gaps, three store_done pulses at write cycles 4, 8 and 12.
